// File: rtl/alu_pkg.sv
// ALU decode package: operation enum, opcode/func encodings, sequencer FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,
    OP_XOR  = 4'd1,
    OP_OR   = 4'd2,
    OP_AND  = 4'd3,
    OP_NOR  = 4'd4,
    OP_SLL  = 4'd5,
    OP_SRL  = 4'd6,
    OP_SLT  = 4'd7,
    OP_ADD  = 4'd8,
    OP_ADDU = 4'd9,
    OP_SUB  = 4'd10,
    OP_SUBU = 4'd11,
    OP_MULT = 4'd12,
    OP_DIV  = 4'd13,
    OP_SRA  = 4'd14,
    OP_LUI  = 4'd15
  } alu_op_t;

  // Opcodes
  localparam logic [5:0] OPC_RTYPE  = 6'b000000;
  localparam logic [5:0] OPC_REGIMM = 6'b000001;  // BGEZ family
  localparam logic [5:0] OPC_BEQ    = 6'b000100;
  localparam logic [5:0] OPC_BNE    = 6'b000101;
  localparam logic [5:0] OPC_BLEZ   = 6'b000110;
  localparam logic [5:0] OPC_BGTZ   = 6'b000111;
  localparam logic [5:0] OPC_ADDI   = 6'b001000;
  localparam logic [5:0] OPC_ADDIU  = 6'b001001;
  localparam logic [5:0] OPC_SLTI   = 6'b001010;
  localparam logic [5:0] OPC_ANDI   = 6'b001100;
  localparam logic [5:0] OPC_ORI    = 6'b001101;
  localparam logic [5:0] OPC_XORI   = 6'b001110;
  localparam logic [5:0] OPC_LUI    = 6'b001111;
  localparam logic [5:0] OPC_LW     = 6'b100011;
  localparam logic [5:0] OPC_SW     = 6'b101011;

  // R-type function codes
  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SRA  = 6'b000011;
  localparam logic [5:0] FN_SLLV = 6'b000100;
  localparam logic [5:0] FN_SRLV = 6'b000110;
  localparam logic [5:0] FN_SRAV = 6'b000111;
  localparam logic [5:0] FN_MULT = 6'b011000;
  localparam logic [5:0] FN_DIV  = 6'b011010;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_MDU  = 2'd2
  } seq_state_t;

endpackage

// File: rtl/alu_decode_comb.sv
// Pure combinational {opcode, func} -> ALU operation + shamt_var/is_branch/illegal.
// Latency: 0 cycles (combinational).
// Backpressure: none; the caller registers the result.
// Ports: opcode/func in; op, shamt_var, is_branch, illegal out.
// Config macro: ALU_DECODE_ILLEGAL_EN (flags unlisted encodings; otherwise illegal stays 0).
module alu_decode_comb
  import alu_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] func,
  output alu_op_t    op,
  output logic       shamt_var,
  output logic       is_branch,
  output logic       illegal
);

  always_comb begin
    op        = OP_NOP;
    shamt_var = 1'b0;
    is_branch = 1'b0;
    illegal   = 1'b0;
    if (opcode == OPC_RTYPE) begin
      case (func)
        FN_SLL:  op = OP_SLL;
        FN_SLLV: begin op = OP_SLL; shamt_var = 1'b1; end
        FN_SRL:  op = OP_SRL;
        FN_SRLV: begin op = OP_SRL; shamt_var = 1'b1; end
        FN_SRA:  op = OP_SRA;
        FN_SRAV: begin op = OP_SRA; shamt_var = 1'b1; end
        FN_XOR:  op = OP_XOR;
        FN_SUB:  op = OP_SUB;
        FN_SLT:  op = OP_SLT;
        FN_SUBU: op = OP_SUBU;
        FN_OR:   op = OP_OR;
        FN_NOR:  op = OP_NOR;
        FN_ADDU: op = OP_ADDU;
        FN_MULT: op = OP_MULT;
        FN_DIV:  op = OP_DIV;
        FN_AND:  op = OP_AND;
        FN_ADD:  op = OP_ADD;
        default: begin
`ifdef ALU_DECODE_ILLEGAL_EN
          illegal = 1'b1;
`endif
        end
      endcase
    end else begin
      case (opcode)
        OPC_XORI:  op = OP_XOR;
        OPC_SLTI:  op = OP_SLT;
        OPC_ADDI:  op = OP_ADD;
        OPC_ANDI:  op = OP_AND;
        OPC_ORI:   op = OP_OR;
        OPC_ADDIU: op = OP_ADDU;
        OPC_LUI:   op = OP_LUI;
        // BEQ/BNE compare via subtraction; the other branches are resolved outside the ALU.
        OPC_BEQ, OPC_BNE: begin op = OP_SUB; is_branch = 1'b1; end
        OPC_BLEZ, OPC_BGTZ, OPC_REGIMM: is_branch = 1'b1;
        OPC_SW, OPC_LW: op = OP_ADD;  // address generation
        default: begin
`ifdef ALU_DECODE_ILLEGAL_EN
          illegal = 1'b1;
`endif
        end
      endcase
    end
  end

endmodule

// File: rtl/alu_decode_seq.sv
// Registered, valid/ready ALU-op decoder that holds off new input while MULT/DIV occupy the MDU.
// Latency: 1 cycle from input transfer to out_valid; 1/cycle throughput for non-MDU ops.
// Backpressure: outputs held stable until out_ready; in_ready drops in HOLD without out_ready,
//   on an MDU handoff and for (N-1) cycles afterwards.
// Ports: clk, rst (async active-high); in_valid/in_ready with opcode/func; out_valid/out_ready
//   with alu_operation, shamt_var, is_branch, illegal; mdu_busy.
// Config macro: ALU_DECODE_ILLEGAL_EN (illegal port tied 0 when undefined).
module alu_decode_seq
  import alu_pkg::*;
#(
  parameter int MULT_CYCLES = 4,
  parameter int DIV_CYCLES  = 8,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [5:0] opcode,
  input  logic [5:0] func,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] alu_operation,
  output logic       shamt_var,
  output logic       is_branch,
  output logic       mdu_busy,
  output logic       illegal
);

  // Counter start value after handoff: N-1 busy cycles follow the handoff cycle.
  localparam logic [CNT_W-1:0] MULT_LAST = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV_CYCLES - 1);

  alu_op_t          dec_op;
  logic             dec_shamt_var, dec_is_branch, dec_illegal;

  seq_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             init_q;  // keeps in_ready low until the first edge after reset
  alu_op_t          op_q;
  logic             shamt_q, branch_q, illegal_q;
  logic             load, clear;
  logic             is_mdu;
  logic [CNT_W-1:0] mdu_last;

  alu_decode_comb u_dec (
    .opcode    (opcode),
    .func      (func),
    .op        (dec_op),
    .shamt_var (dec_shamt_var),
    .is_branch (dec_is_branch),
    .illegal   (dec_illegal)
  );

  assign is_mdu   = (op_q == OP_MULT) || (op_q == OP_DIV);
  assign mdu_last = (op_q == OP_DIV) ? DIV_LAST : MULT_LAST;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    load      = 1'b0;
    clear     = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    mdu_busy  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = init_q;
        if (init_q && in_valid) begin
          load    = 1'b1;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (is_mdu) begin
            clear = 1'b1;
            if (mdu_last != '0) begin
              cnt_d   = mdu_last;
              state_d = ST_MDU;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            in_ready = 1'b1;
            if (in_valid) begin
              load = 1'b1;
            end else begin
              clear   = 1'b1;
              state_d = ST_IDLE;
            end
          end
        end
      end
      ST_MDU: begin
        mdu_busy = 1'b1;
        cnt_d    = cnt_q - CNT_W'(1);
        // Leave while the count steps 1->0 so the busy window is exactly N-1 cycles.
        if (cnt_q <= CNT_W'(1)) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      init_q    <= 1'b0;
      op_q      <= OP_NOP;
      shamt_q   <= 1'b0;
      branch_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      init_q  <= 1'b1;
      if (load) begin
        op_q      <= dec_op;
        shamt_q   <= dec_shamt_var;
        branch_q  <= dec_is_branch;
        illegal_q <= dec_illegal;
      end else if (clear) begin
        op_q      <= OP_NOP;
        shamt_q   <= 1'b0;
        branch_q  <= 1'b0;
        illegal_q <= 1'b0;
      end
    end
  end

  assign alu_operation = op_q;
  assign shamt_var     = shamt_q;
  assign is_branch     = branch_q;
  assign illegal       = illegal_q;

endmodule

// File: doc/alu_decode_seq.md
Name: alu_decode_seq

Overview:
- Registered, handshaked successor to the combinational ALU-operation decoder.
- Accepts one {opcode, func} per valid/ready transfer and emits a registered 4-bit ALU operation plus side-band decode flags.
- Sequences multi-cycle MULT/DIV by holding off new instructions for a parameterised number of cycles.
- Sits between the ID stage and the EX-stage ALU/MDU.

Parameters:
- MULT_CYCLES, 4: cycles the MDU stays busy after a MULT leaves the block; legal range 1..255.
- DIV_CYCLES, 8: cycles the MDU stays busy after a DIV leaves the block; legal range 1..255.
- CNT_W, 8: width of the busy down-counter; must hold max(MULT_CYCLES, DIV_CYCLES)-1.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  opcode/func valid.
- in_ready  out  1  block can accept this cycle.
- opcode  in  6  instruction opcode.
- func  in  6  R-type function field.
- out_valid  out  1  decoded operation valid.
- out_ready  in  1  EX stage accepts the decoded operation.
- alu_operation  out  4  decoded operation code (package enum).
- shamt_var  out  1  shift amount comes from rs, not shamt (SLLV/SRLV/SRAV).
- is_branch  out  1  BEQ/BNE/BLEZ/BGTZ/BGEZ.
- mdu_busy  out  1  multi-cycle MULT/DIV in progress.
- illegal  out  1  see Optional Feature.

Behaviour:
- Reset (async, while rst=1): state=IDLE, counter=0, held registers cleared. Outputs: out_valid=0, alu_operation=NOP(0), shamt_var=0, is_branch=0, mdu_busy=0, illegal=0, in_ready=0. in_ready rises on the first clock edge after rst deasserts.
- Decode table, opcode 000000, by func:
  - 000000 SLL; 000100 SLL (var); 000010 SRL; 000110 SRL (var); 000011 SRA; 000111 SRA (var).
  - 100110 XOR; 100010 SUB; 101010 SLT; 100011 SUBU; 100101 OR; 100111 NOR; 100001 ADDU; 011000 MULT; 011010 DIV; 100100 AND; 100000 ADD.
  - Any other func gives NOP.
- Decode table, other opcodes:
  - 001110 XOR; 001010 SLT; 001000 ADD; 001100 AND; 001101 OR; 001001 ADDU; 001111 LUI.
  - 000100 and 000101 give SUB with is_branch=1.
  - 000110, 000111 and 000001 give NOP with is_branch=1.
  - 101011 and 100011 give ADD.
  - Any other opcode gives NOP.
- shamt_var=1 only for func 000100, 000110 and 000111 under opcode 000000.
- FSM has three states: IDLE, HOLD and MDU.
  - IDLE: in_ready=1, out_valid=0. On in_valid, capture the decode and go to HOLD. Latency is exactly 1 cycle from transfer to out_valid.
  - HOLD: out_valid=1 and outputs are stable until out_ready.
    - On out_ready with a non-MDU operation, in_ready=1 in the same cycle (back-to-back throughput of 1 per cycle). A simultaneous in_valid reloads the registers and the block stays in HOLD; otherwise it goes to IDLE.
    - On out_ready with MULT/DIV, in_ready=0. If the cycle count N is greater than 1, load counter=N-1 and go to MDU. If N==1, go to IDLE.
    - Without out_ready, in_ready=0.
  - MDU: mdu_busy=1, out_valid=0, in_ready=0. The counter decrements each cycle; when counter==0 the block goes to IDLE. MULT therefore blocks input for MULT_CYCLES-1 cycles after the handoff cycle.
- Decoded outputs reset to NOP when the block leaves HOLD without a reload.
- Reset mid-HOLD or mid-MDU aborts immediately; there is no replay.

Optional Feature:
- Macro: ALU_DECODE_ILLEGAL_EN.
- Defined: illegal=1 alongside out_valid for any opcode, or opcode-000000 func, not listed in the decode table. alu_operation is NOP in that case.
- Undefined: the illegal port exists but is tied 0, and unknown encodings silently decode to NOP.

Decomposition:
- Package alu_pkg holds:
  - The 4-bit alu_op_t enum: NOP=0, XOR=1, OR=2, AND=3, NOR=4, SLL=5, SRL=6, SLT=7, ADD=8, ADDU=9, SUB=10, SUBU=11, MULT=12, DIV=13, SRA=14, LUI=15.
  - The opcode and func localparams.
  - The FSM state typedef.
- One natural sub-module, alu_decode_comb: the pure combinational decode (opcode, func to op, shamt_var, is_branch, illegal), instantiated once in front of the HOLD register.

Test Plan:
- Reset/idle: assert rst mid-cycle, release it -> all outputs 0 and alu_operation=0 during reset; in_ready=1 one edge after release.
- Streaming: in_valid held, out_ready=1, inputs opcode=000000/func=100000 then opcode=001101 -> out_valid every cycle, alu_operation 8 then 2, each exactly 1 cycle after transfer, no bubbles.
- Backpressure: out_ready=0 for 3 cycles with XORI (001110) held -> alu_operation=1 is stable and in_ready=0 throughout; it transfers on the first out_ready=1 cycle.
- MULT sequencing: MULT_CYCLES=4, send func 011000 -> alu_operation=12 for one transfer, then mdu_busy=1 and in_ready=0 for 3 cycles; the next instruction is accepted on the 4th cycle. Repeat with DIV_CYCLES=1 -> no busy cycles.
- Shifts and branches: func 000110 -> SRL with shamt_var=1; func 000010 -> SRL with shamt_var=0; opcode 000101 -> SUB with is_branch=1; opcode 000111 -> NOP with is_branch=1.
- Illegal encoding: opcode 111111 with the macro defined -> illegal=1 and op NOP; without the macro -> illegal=0 and op NOP. Also assert rst during the MDU state -> mdu_busy drops to 0 immediately.
